// File: rtl/gate_reduce_pkg.sv
// Shared types for the gated reduction pipeline: operation codes,
// FSM state encoding and a small helper for the per-op identity value.
package gate_reduce_pkg;

   // Operation applied across masked operands and across beats.
   typedef enum logic [1:0] {
      OP_AND  = 2'd0,
      OP_OR   = 2'd1,
      OP_XOR  = 2'd2,
      OP_NAND = 2'd3
   } op_e;

   // IDLE: no open frame, ACC: frame open, HOLD: result waiting.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   // AND and NAND share the all-ones identity and accumulate as AND.
   function automatic logic is_and_like(input op_e op);
      return (op == OP_AND) || (op == OP_NAND);
   endfunction

endpackage

// File: rtl/gate_reduce_comb.sv
// Per-beat masked reduction: data_i holds NIN operands of WIDTH bits,
// mask_i selects participants, op_i picks the operator, r_o is the result.
module gate_reduce_comb
   import gate_reduce_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int NIN   = 3
) (
   input  logic [NIN*WIDTH-1:0] data_i,
   input  logic [NIN-1:0]       mask_i,
   input  op_e                  op_i,
   output logic [WIDTH-1:0]     r_o
);

   always_comb begin
      // Start from the identity so masked-off operands drop out.
      r_o = is_and_like(op_i) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
      for (int k = 0; k < NIN; k++) begin
         if (mask_i[k]) begin
            case (op_i)
               OP_AND,
               OP_NAND: r_o = r_o & data_i[k*WIDTH +: WIDTH];
               OP_OR:   r_o = r_o | data_i[k*WIDTH +: WIDTH];
               OP_XOR:  r_o = r_o ^ data_i[k*WIDTH +: WIDTH];
               default: r_o = r_o;
            endcase
         end
      end
   end

endmodule

// File: rtl/gate_reduce_pipe.sv
// Frame-level gated reduction: beats in (valid/ready), one result out.
// Ports: clk, rst, in_valid/in_ready/in_data/in_mask/in_op/in_last, out_valid/out_ready/out_data/out_beats.
module gate_reduce_pipe
   import gate_reduce_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int NIN   = 3,
   parameter int CNTW  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NIN*WIDTH-1:0] in_data,
   input  logic [NIN-1:0]       in_mask,
   input  logic [1:0]           in_op,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [CNTW-1:0]      out_beats
);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   op_e               beat_op;
   logic [WIDTH-1:0]  acc_q, acc_d;
   logic [WIDTH-1:0]  acc_comb;
   logic [WIDTH-1:0]  beat_r;
   logic [CNTW-1:0]   beats_q, beats_d;
   logic              accept;

   // Ready depends only on state, never on out_ready.
   assign in_ready  = (state_q != ST_HOLD);
   assign out_valid = (state_q == ST_HOLD);
   assign accept    = in_valid && in_ready;

   // The first beat uses the live op; later beats use the latched one.
   assign beat_op = (state_q == ST_IDLE) ? op_e'(in_op) : op_q;

   gate_reduce_comb #(
      .WIDTH (WIDTH),
      .NIN   (NIN)
   ) u_comb (
      .data_i (in_data),
      .mask_i (in_mask),
      .op_i   (beat_op),
      .r_o    (beat_r)
   );

   always_comb begin
      case (op_q)
         OP_AND,
         OP_NAND: acc_comb = acc_q & beat_r;
         OP_OR:   acc_comb = acc_q | beat_r;
         OP_XOR:  acc_comb = acc_q ^ beat_r;
         default: acc_comb = acc_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      acc_d   = acc_q;
      beats_d = beats_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               acc_d   = beat_r;
               op_d    = op_e'(in_op);
               beats_d = CNTW'(1);
               state_d = in_last ? ST_HOLD : ST_ACC;
            end
         end
         ST_ACC: begin
            if (accept) begin
               acc_d = acc_comb;
               if (beats_q != {CNTW{1'b1}}) begin
                  beats_d = beats_q + CNTW'(1);
               end
               if (in_last) begin
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_AND;
         acc_q   <= '0;
         beats_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         beats_q <= beats_d;
      end
   end

   // NAND is accumulated as AND and inverted only at the output.
   assign out_data  = (op_q == OP_NAND) ? ~acc_q : acc_q;
   assign out_beats = beats_q;

endmodule

// File: tb/tb_gate_reduce_pipe.sv
// Self-checking bench for gate_reduce_pipe (WIDTH=2, NIN=3, CNTW=8):
// frame-level model plus directed vectors with literal expectations.
module tb_gate_reduce_pipe;

   localparam int W = 2;
   localparam int N = 3;
   localparam int C = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_mask;
   logic [1:0]     in_op;
   logic           in_last;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_data;
   logic [C-1:0]   out_beats;

   always #5 clk = ~clk;

   gate_reduce_pipe #(
      .WIDTH (W),
      .NIN   (N),
      .CNTW  (C)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mask   (in_mask),
      .in_op     (in_op),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_beats (out_beats)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] d;
      logic [C-1:0] b;
   } exp_t;

   exp_t exp_q[$];

   // Frame model: the frame result is the op applied over every masked
   // operand of every beat, so only per-bit counts of ones are kept.
   logic       m_open = 1'b0;
   logic [1:0] m_op;
   int         m_n;
   int         m_cnt;
   int         m_ones[W];

   function automatic logic bit_res(input logic [1:0] op, input int ones, input int cnt);
      case (op)
         2'd0:    return ones == cnt;
         2'd1:    return ones > 0;
         2'd2:    return (ones % 2) == 1;
         default: return !(ones == cnt);
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_beat(input logic [N*W-1:0] d, input logic [N-1:0] m,
                             input logic [1:0] o, input logic l);
      exp_t e;
      if (!m_open) begin
         m_open = 1'b1;
         m_op   = o;
         m_n    = 0;
         m_cnt  = 0;
         for (int b = 0; b < W; b++) m_ones[b] = 0;
      end
      for (int k = 0; k < N; k++) begin
         if (m[k]) begin
            m_cnt++;
            for (int b = 0; b < W; b++) m_ones[b] += int'(d[k*W+b]);
         end
      end
      m_n++;
      if (l) begin
         for (int b = 0; b < W; b++) e.d[b] = bit_res(m_op, m_ones[b], m_cnt);
         e.b = (m_n > 255) ? 8'd255 : C'(m_n);
         exp_q.push_back(e);
         m_open = 1'b0;
      end
   endtask

   // Entered and left at posedge+1; the beat is accepted at the edge inside.
   task automatic send_beat(input logic [N*W-1:0] d, input logic [N-1:0] m,
                            input logic [1:0] o, input logic l);
      int c;
      in_data  = d;
      in_mask  = m;
      in_op    = o;
      in_last  = l;
      in_valid = 1'b1;
      c = 0;
      @(negedge clk);
      while (!in_ready && c < 50) begin
         @(negedge clk);
         c++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout got=0 exp=1");
      end
      step();
      if (in_ready !== 1'bx) model_beat(d, m, o, l);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Every cycle: valid/ready follow the model's pending result, and a
   // pending result must be presented unchanged until it is consumed.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         checks++;
         if (out_valid !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL cmp_out_valid got=%0b exp=%0b", out_valid, exp_q.size() != 0);
         end
         checks++;
         if (in_ready !== (exp_q.size() == 0)) begin
            errors++;
            $display("FAIL cmp_in_ready got=%0b exp=%0b", in_ready, exp_q.size() == 0);
         end
         if (exp_q.size() != 0) begin
            checks++;
            if (out_data !== exp_q[0].d || out_beats !== exp_q[0].b) begin
               errors++;
               $display("FAIL cmp_result got=%0h/%0d exp=%0h/%0d",
                        out_data, out_beats, exp_q[0].d, exp_q[0].b);
            end
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  pv;
      logic [31:0] iv;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mask   = '0;
      in_op     = 2'd0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (2) step();
      rst = 1'b0;

      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_beats", out_beats, 0);
      step();

      // Single-beat AND, operand 2 masked off.
      send_beat({2'b10, 2'b01, 2'b11}, 3'b011, 2'd0, 1'b1);
      @(negedge clk);
      chk("and1_valid", out_valid, 1);
      chk("and1_data", out_data, 2'b01);
      chk("and1_beats", out_beats, 1);
      step();

      for (int p = 0; p < 16; p++) begin
         pv = p[3:0];
         send_beat({2'b00, pv[3:2], pv[1:0]}, 3'b011, 2'd0, 1'b1);
         @(negedge clk);
         chk($sformatf("sweep_%0d", p), out_data, pv[1:0] & pv[3:2]);
         step();
      end

      // XOR over three beats with idle gaps and in_op toggling mid-frame.
      send_beat({4'b0000, 2'b01}, 3'b001, 2'd2, 1'b0);
      repeat (3) step();
      send_beat({4'b0000, 2'b11}, 3'b001, 2'd0, 1'b0);
      step();
      send_beat({4'b0000, 2'b10}, 3'b001, 2'd3, 1'b1);
      @(negedge clk);
      chk("xor3_data", out_data, 2'b00);
      chk("xor3_beats", out_beats, 3);
      step();

      send_beat({2'b10, 2'b11, 2'b11}, 3'b111, 2'd3, 1'b1);
      @(negedge clk);
      chk("nand_full", out_data, 2'b01);
      step();
      send_beat({2'b10, 2'b10, 2'b11}, 3'b000, 2'd3, 1'b1);
      @(negedge clk);
      chk("nand_mask0", out_data, 2'b00);
      step();

      // Back-pressure on the result.
      out_ready = 1'b0;
      send_beat({2'b01, 2'b11, 2'b10}, 3'b101, 2'd1, 1'b1);
      for (int h = 0; h < 5; h++) begin
         @(negedge clk);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_data", out_data, 2'b11);
         chk("hold_beats", out_beats, 1);
         step();
      end
      out_ready = 1'b1;
      step();
      @(negedge clk);
      chk("release_in_ready", in_ready, 1);
      chk("release_valid", out_valid, 0);
      step();

      // Reset mid-frame, with a last beat offered on the same edge.
      send_beat({2'b11, 2'b11, 2'b11}, 3'b111, 2'd0, 1'b0);
      send_beat({2'b11, 2'b01, 2'b11}, 3'b111, 2'd0, 1'b0);
      in_data  = {2'b11, 2'b11, 2'b11};
      in_mask  = 3'b111;
      in_last  = 1'b1;
      in_valid = 1'b1;
      rst      = 1'b1;
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      m_open   = 1'b0;
      @(negedge clk);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_beats", out_beats, 0);
      chk("midrst_data", out_data, 0);
      chk("midrst_in_ready", in_ready, 1);
      step();
      send_beat({2'b00, 2'b00, 2'b10}, 3'b001, 2'd1, 1'b1);
      @(negedge clk);
      chk("after_rst_beats", out_beats, 1);
      chk("after_rst_data", out_data, 2'b10);
      step();

      // Long OR frame: beat counter saturates.
      for (int i = 0; i < 300; i++) begin
         iv = i;
         send_beat(iv[5:0], iv[2:0], 2'd1, i == 299);
      end
      @(negedge clk);
      chk("sat_beats", out_beats, 255);
      chk("sat_data", out_data, 2'b11);
      step();

      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gate_reduce_pipe.md
GATE_REDUCE_PIPE -- requirements
Module: gate_reduce_pipe

Interface
REQ-001 Parameter WIDTH, default 2, bit width of each input operand and of the result.
REQ-002 Parameter NIN, default 3, number of operand inputs per beat (NIN >= 1).
REQ-003 Parameter CNTW, default 8, width of the beat counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  beat offered.
REQ-007 in_ready  output  1  beat accepted when in_valid && in_ready at a rising edge.
REQ-008 in_data  input  NIN*WIDTH  operands; operand k occupies bits [k*WIDTH +: WIDTH].
REQ-009 in_mask  input  NIN  operand k participates only when in_mask[k]=1.
REQ-010 in_op  input  2  0=AND, 1=OR, 2=XOR, 3=NAND; sampled on first beat of a frame only.
REQ-011 in_last  input  1  marks final beat of a frame.
REQ-012 out_valid  output  1  frame result available.
REQ-013 out_ready  input  1  result consumed when out_valid && out_ready at a rising edge.
REQ-014 out_data  output  WIDTH  frame result.
REQ-015 out_beats  output  CNTW  number of beats accepted in the frame, saturating.

Function
REQ-016 Beat reduction r SHALL be the bitwise op over all masked-in operands; masked-off operands contribute identity (all ones for AND/NAND, zero for OR/XOR).
REQ-017 Mask all zero SHALL give r = identity value for the op.
REQ-018 FSM states SHALL be IDLE (no open frame), ACC (frame open), HOLD (result waiting).
REQ-019 IDLE: accepted beat loads acc=r, latches op, beats=1; goes to HOLD if in_last, else ACC.
REQ-020 ACC: accepted beat sets acc = acc op r (NAND accumulates as AND), beats+1 saturating at 2^CNTW-1; goes to HOLD if in_last.
REQ-021 HOLD: out_valid=1; out_data = acc, or ~acc when latched op is NAND; out_ready=1 returns to IDLE next cycle.
REQ-022 in_ready SHALL be 1 in IDLE and ACC, 0 in HOLD; no combinational path from out_ready to in_ready.
REQ-023 Latency: last beat accepted at edge t -> out_valid high after edge t, i.e. one cycle.
REQ-024 in_op changes while in ACC SHALL be ignored until the next frame.
REQ-025 out_data and out_beats SHALL remain stable throughout HOLD; out_ready outside HOLD is ignored.
REQ-026 in_valid=0 in ACC SHALL hold state indefinitely with no change to acc or beats.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, acc=0, beats=0, out_valid=0, out_data=0, out_beats=0; in_ready=1 from the following cycle.
REQ-028 Reset in ACC or HOLD SHALL discard the frame; no result is emitted for it.
REQ-029 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-030 Shared package gate_reduce_pkg SHALL hold the op codes (OP_AND, OP_OR, OP_XOR, OP_NAND) and the FSM state encoding.
REQ-031 Per-beat masked reduction SHALL be one combinational sub-module, gate_reduce_comb, parametrised by WIDTH and NIN.
REQ-032 Top level SHALL contain only the FSM, acc/beat registers and handshake logic.

Verification (WIDTH=2, NIN=3, CNTW=8)
REQ-033 Single beat AND, mask 3'b011, ops 2'b11,2'b01,x, last=1 -> out_data 2'b01, out_beats 1, out_valid one cycle later.
REQ-034 Full 16-pattern sweep of ops 0/1 with mask 3'b011, op AND, one beat per frame -> out_data = op0 & op1 for every pattern.
REQ-035 Three-beat XOR frame, r = 2'b01, 2'b11, 2'b10 -> out_data 2'b00, out_beats 3; in_op toggled mid-frame has no effect.
REQ-036 NAND single beat, mask 3'b111, ops 2'b11,2'b11,2'b10 -> out_data 2'b01; mask 3'b000 -> out_data 2'b00.
REQ-037 Hold out_ready=0 for 5 cycles in HOLD -> in_ready=0, out_data/out_beats unchanged; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-038 Assert rst during ACC after 2 beats -> no out_valid, next frame starts with out_beats counting from 1; 300-beat frame -> out_beats 255.
